// File: rtl/ov5640_cfg_pkg.sv
// Shared definitions for the OV5640 init sequencer: FSM state encoding,
// init-ROM entry field positions and the microsecond-to-cycle conversion.
package ov5640_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PWR_WAIT = 4'd1,
        ST_FETCH    = 4'd2,
        ST_LOAD     = 4'd3,
        ST_REQ      = 4'd4,
        ST_RETRY    = 4'd5,
        ST_RST_WAIT = 4'd6,
        ST_DONE     = 4'd7,
        ST_ERROR    = 4'd8
    } state_t;

    localparam int REG_ADDR_MSB = 23;
    localparam int REG_ADDR_LSB = 8;
    localparam int REG_DATA_MSB = 7;
    localparam int REG_DATA_LSB = 0;

    function automatic int US_TO_CYC(input int us, input int clk_freq);
        return us * (clk_freq / 32'sd1_000_000);
    endfunction

endpackage

// File: rtl/ov5640_us_timer.sv
// Loadable down-counter used for the power-up and post-reset waits;
// expired is high while the count sits at zero.
module ov5640_us_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             count,
    output logic             expired
);

    logic [WIDTH-1:0] cnt_r;

    // Reload has priority; otherwise decrement while enabled and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (count && (cnt_r != {WIDTH{1'b0}})) begin
            cnt_r <= cnt_r - WIDTH'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == {WIDTH{1'b0}});

endmodule

// File: rtl/ov5640_init_sequencer.sv
// Walks the OV5640 register-init ROM and issues one SCCB write per entry,
// inserting the power-up and soft-reset waits and retrying NACKed writes.
module ov5640_init_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 24,
    parameter int REG_NUM    = 252,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int PWRUP_US   = 20000,
    parameter int RST_INDEX  = 1,
    parameter int RST_US     = 5000,
    parameter int MAX_RETRY  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic                  wr_req,
    output logic [15:0]           wr_reg_addr,
    output logic [7:0]            wr_reg_data,
    input  logic                  wr_done,
    input  logic                  wr_nack,
    output logic                  init_busy,
    output logic                  init_done,
    output logic                  init_error,
    output logic [ADDR_WIDTH-1:0] err_index
);

    import ov5640_cfg_pkg::*;

    localparam int PWR_CYC = US_TO_CYC(PWRUP_US, CLK_FREQ);
    localparam int RST_CYC = US_TO_CYC(RST_US, CLK_FREQ);
    localparam int MAX_CYC = (PWR_CYC > RST_CYC) ? PWR_CYC : RST_CYC;
    localparam int TMR_W   = (MAX_CYC > 32'sd2) ? $clog2(MAX_CYC) : 32'sd1;
    localparam int RETRY_W = (MAX_RETRY > 32'sd1) ? $clog2(MAX_RETRY + 32'sd1) : 32'sd1;
    // Timer counts load_val..0 inclusive, so a wait of N cycles loads N-1.
    localparam logic [TMR_W-1:0] PWR_LOAD = TMR_W'((PWR_CYC > 32'sd0) ? PWR_CYC - 32'sd1 : 32'sd0);
    localparam logic [TMR_W-1:0] RST_LOAD = TMR_W'((RST_CYC > 32'sd0) ? RST_CYC - 32'sd1 : 32'sd0);

    state_t                state_r, state_next_s;
    logic [ADDR_WIDTH-1:0] idx_r, idx_next_s;
    logic [RETRY_W-1:0]    retry_r, retry_next_s;
    logic                  last_s, rst_point_s, retry_out_s, start_acc_s;
    logic                  tmr_load_s, tmr_count_s, tmr_expired_s;
    logic [TMR_W-1:0]      tmr_val_s;

    logic [ADDR_WIDTH-1:0] rom_addr_r, err_index_r;
    logic                  wr_req_r, init_busy_r, init_done_r, init_error_r;
    logic [15:0]           wr_reg_addr_r;
    logic [7:0]            wr_reg_data_r;

    assign last_s      = (32'(idx_r) == (REG_NUM - 32'sd1));
    assign rst_point_s = (32'(idx_r) == RST_INDEX);
    assign retry_out_s = (32'(retry_r) >= MAX_RETRY);

    // Next-state, index and retry bookkeeping.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        retry_next_s = retry_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_next_s = ST_PWR_WAIT;
                    idx_next_s   = {ADDR_WIDTH{1'b0}};
                    retry_next_s = {RETRY_W{1'b0}};
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_PWR_WAIT: begin
                if (tmr_expired_s) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_PWR_WAIT;
                end
            end
            ST_FETCH: state_next_s = ST_LOAD;
            ST_LOAD:  state_next_s = ST_REQ;
            ST_REQ: begin
                if (wr_nack) begin
                    if (retry_out_s) begin
                        state_next_s = ST_ERROR;
                    end else begin
                        state_next_s = ST_RETRY;
                        retry_next_s = retry_r + RETRY_W'(1);
                    end
                end else if (wr_done) begin
                    retry_next_s = {RETRY_W{1'b0}};
                    if (rst_point_s) begin
                        state_next_s = ST_RST_WAIT;
                    end else if (last_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_FETCH;
                        idx_next_s   = idx_r + ADDR_WIDTH'(1);
                    end
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_RETRY: state_next_s = ST_REQ;
            ST_RST_WAIT: begin
                if (!tmr_expired_s) begin
                    state_next_s = ST_RST_WAIT;
                end else if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_FETCH;
                    idx_next_s   = idx_r + ADDR_WIDTH'(1);
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    assign start_acc_s = (state_next_s == ST_PWR_WAIT) && (state_r != ST_PWR_WAIT);
    assign tmr_load_s  = start_acc_s ||
                         ((state_next_s == ST_RST_WAIT) && (state_r != ST_RST_WAIT));
    assign tmr_val_s   = (state_next_s == ST_RST_WAIT) ? RST_LOAD : PWR_LOAD;
    assign tmr_count_s = (state_r == ST_PWR_WAIT) || (state_r == ST_RST_WAIT);

    ov5640_us_timer #(
        .WIDTH    (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .count    (tmr_count_s),
        .expired  (tmr_expired_s)
    );

    // FSM, index and retry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= {ADDR_WIDTH{1'b0}};
            retry_r <= {RETRY_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            retry_r <= retry_next_s;
        end
    end

    // Output registers, all decoded from the upcoming state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_r    <= {ADDR_WIDTH{1'b0}};
            wr_req_r      <= 1'b0;
            wr_reg_addr_r <= 16'h0000;
            wr_reg_data_r <= 8'h00;
            init_busy_r   <= 1'b0;
            init_done_r   <= 1'b0;
            init_error_r  <= 1'b0;
            err_index_r   <= {ADDR_WIDTH{1'b0}};
        end else begin
            rom_addr_r   <= (state_next_s == ST_FETCH) ? idx_next_s : rom_addr_r;
            wr_req_r     <= (state_next_s == ST_REQ);
            init_busy_r  <= (state_next_s != ST_IDLE) && (state_next_s != ST_DONE) &&
                            (state_next_s != ST_ERROR);
            init_done_r  <= (state_next_s == ST_DONE);
            init_error_r <= (state_next_s == ST_ERROR);
            // ROM word for rom_addr is valid at the end of LOAD (registered read).
            if (state_r == ST_LOAD) begin
                wr_reg_addr_r <= rom_q[REG_ADDR_MSB:REG_ADDR_LSB];
                wr_reg_data_r <= rom_q[REG_DATA_MSB:REG_DATA_LSB];
            end else begin
                wr_reg_addr_r <= wr_reg_addr_r;
                wr_reg_data_r <= wr_reg_data_r;
            end
            if ((state_r == ST_REQ) && (state_next_s == ST_ERROR)) begin
                err_index_r <= idx_r;
            end else if (start_acc_s) begin
                err_index_r <= {ADDR_WIDTH{1'b0}};
            end else begin
                err_index_r <= err_index_r;
            end
        end
    end

    assign rom_addr    = rom_addr_r;
    assign wr_req      = wr_req_r;
    assign wr_reg_addr = wr_reg_addr_r;
    assign wr_reg_data = wr_reg_data_r;
    assign init_busy   = init_busy_r;
    assign init_done   = init_done_r;
    assign init_error  = init_error_r;
    assign err_index   = err_index_r;

endmodule

// File: tb/tb_ov5640_init_sequencer.sv
// Directed bench for ov5640_init_sequencer: a ROM model, an SCCB responder and a
// scoreboard of expected writes with their cycle gaps.
module tb_ov5640_init_sequencer;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          gmin;
        int          gmax;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [23:0] rom_q = 24'h0;
    logic        wr_req;
    logic [15:0] wr_reg_addr;
    logic [7:0]  wr_reg_data;
    logic        wr_done, wr_nack;
    logic        init_busy, init_done, init_error;
    logic [7:0]  err_index;

    logic [23:0] rom [4];
    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          ref_cyc = 0;
    logic        arm_start = 1'b0;
    int          nack_left = 0;
    logic [7:0]  nack_data = 8'h42;

    ov5640_init_sequencer #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (24),
        .REG_NUM    (4),
        .CLK_FREQ   (1_000_000),
        .PWRUP_US   (10),
        .RST_INDEX  (1),
        .RST_US     (5),
        .MAX_RETRY  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .wr_req      (wr_req),
        .wr_reg_addr (wr_reg_addr),
        .wr_reg_data (wr_reg_data),
        .wr_done     (wr_done),
        .wr_nack     (wr_nack),
        .init_busy   (init_busy),
        .init_done   (init_done),
        .init_error  (init_error),
        .err_index   (err_index)
    );

    always #5 clk = ~clk;

    // Init ROM with a one-cycle registered read.
    always @(posedge clk) rom_q <= (rom_addr < 8'd4) ? rom[rom_addr[1:0]] : 24'h000000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        vectors++;
        assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic push(input int idx, input int gmin, input int gmax);
        exp_t e;
        e.addr = rom[idx][23:8];
        e.data = rom[idx][7:0];
        e.gmin = gmin;
        e.gmax = gmax;
        exp_q.push_back(e);
    endtask

    // Full table with no NACKs: entry 1 is followed by the 5-cycle reset wait.
    task automatic push_table();
        push(0, 10, 13);
        push(1, 3, 3);
        push(2, 8, 8);
        push(3, 3, 3);
    endtask

    task automatic pulse_start(input logic armed);
        @(posedge clk); #1;
        arm_start = armed;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (init_done || init_error) break;
        end
    endtask

    task automatic wait_req(input logic [7:0] data);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (wr_req && (wr_reg_data == data)) break;
        end
    endtask

    task automatic check_finished(input string tag);
        check({tag, "_done"}, init_done, 1'b1);
        check({tag, "_busy"}, init_busy, 1'b0);
        check({tag, "_error"}, init_error, 1'b0);
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    // SCCB responder plus scoreboard monitor, both sampling on the falling edge.
    initial begin
        exp_t e;
        int   hi_cnt;
        logic req_prev;
        hi_cnt = 0;
        req_prev = 1'b0;
        wr_done = 1'b0;
        wr_nack = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            wr_done = 1'b0;
            wr_nack = 1'b0;
            if (start && arm_start) begin
                ref_cyc = cyc;
                arm_start = 1'b0;
            end
            if (wr_req && !req_prev) begin
                check("req_expected", (exp_q.size() > 0), 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("write", {wr_reg_addr, wr_reg_data}, {e.addr, e.data});
                    check_range("gap", cyc - ref_cyc, e.gmin, e.gmax);
                end
            end
            req_prev = wr_req;
            if (wr_req) begin
                hi_cnt++;
                if (hi_cnt == 3) begin
                    if ((nack_left > 0) && (wr_reg_data == nack_data)) begin
                        wr_nack = 1'b1;
                        nack_left--;
                    end else begin
                        wr_done = 1'b1;
                    end
                    ref_cyc = cyc;
                end
            end else begin
                hi_cnt = 0;
            end
        end
    end

    initial begin
        rom[0] = 24'h3103_11;
        rom[1] = 24'h3008_82;
        rom[2] = 24'h3008_42;
        rom[3] = 24'h3103_03;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req", wr_req, 1'b0);
        check("rst_busy", init_busy, 1'b0);
        check("rst_done", init_done, 1'b0);
        check("rst_error", init_error, 1'b0);
        check("rst_err_index", err_index, 8'h00);
        check("rst_rom_addr", rom_addr, 8'h00);
        rst_n = 1'b1;

        // Normal run, with ignored start pulses in PWR_WAIT and REQ.
        push_table();
        pulse_start(1'b1);
        check("run1_busy", init_busy, 1'b1);
        repeat (3) @(posedge clk);
        pulse_start(1'b0);
        check("run1_busy_pwr", init_busy, 1'b1);
        wait_req(8'h11);
        pulse_start(1'b0);
        wait_end();
        check_finished("run1");
        check("run1_req_low", wr_req, 1'b0);

        // Start from DONE reruns the whole table.
        push_table();
        pulse_start(1'b1);
        check("run2_done_clr", init_done, 1'b0);
        check("run2_busy", init_busy, 1'b1);
        wait_end();
        check_finished("run2");

        // One NACK on entry 2: one-cycle drop and same write re-issued.
        nack_left = 1;
        push(0, 10, 13);
        push(1, 3, 3);
        push(2, 8, 8);
        push(2, 2, 2);
        push(3, 3, 3);
        pulse_start(1'b1);
        wait_end();
        check_finished("nack1");

        // Three NACKs on entry 2 exhaust the retries.
        nack_left = 3;
        push(0, 10, 13);
        push(1, 3, 3);
        push(2, 8, 8);
        push(2, 2, 2);
        push(2, 2, 2);
        pulse_start(1'b1);
        wait_end();
        check("err_flag", init_error, 1'b1);
        check("err_index", err_index, 8'h02);
        check("err_busy", init_busy, 1'b0);
        check("err_done", init_done, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("err_req_low", wr_req, 1'b0);
        check("err_pending", exp_q.size(), 0);

        // Reset mid-transaction on entry 2, then a clean restart.
        nack_left = 0;
        push(0, 10, 13);
        push(1, 3, 3);
        push(2, 8, 8);
        pulse_start(1'b1);
        check("restart_err_clr", init_error, 1'b0);
        check("restart_idx_clr", err_index, 8'h00);
        wait_req(8'h42);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_req", wr_req, 1'b0);
        check("arst_busy", init_busy, 1'b0);
        check("arst_reg_addr", wr_reg_addr, 16'h0000);
        check("arst_reg_data", wr_reg_data, 8'h00);
        check("arst_rom_addr", rom_addr, 8'h00);
        check("arst_pending", exp_q.size(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_table();
        pulse_start(1'b1);
        wait_end();
        check_finished("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
